// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the six-stage pipeline (F1, F2, D, E, M, W).
// Prioritises dmem wait, divide, redirect, pending redirect, load-use and imem wait.
module pipe_hazard_ctrl #(
   parameter int DIV_LAT = 8
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        imem_ready,
   input  logic        dmem_ready,
   input  logic        m_mem_req,
   input  logic        e_redirect,
   input  logic [31:0] e_target,
   input  logic        e_div,
   input  logic        e_mem_read,
   input  logic [4:0]  e_rd,
   input  logic [4:0]  d_rs1,
   input  logic [4:0]  d_rs2,
   input  logic        d_use_rs1,
   input  logic        d_use_rs2,
   output logic        pc_stall,
   output logic        pc_redirect,
   output logic [31:0] pc_target,
   output logic        f1f2_stall,
   output logic        f1f2_flush,
   output logic        f2d_stall,
   output logic        f2d_flush,
   output logic        de_stall,
   output logic        de_flush,
   output logic        em_stall,
   output logic        em_flush,
   output logic        mw_flush,
   output logic        div_done
);

   localparam int CW = $clog2(DIV_LAT);

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   typedef struct packed {
      logic        pc_stall;
      logic        pc_redirect;
      logic [31:0] pc_target;
      logic        f1f2_stall;
      logic        f1f2_flush;
      logic        f2d_stall;
      logic        f2d_flush;
      logic        de_stall;
      logic        de_flush;
      logic        em_stall;
      logic        em_flush;
      logic        mw_flush;
   } ctl_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic            redir_pend, pend_nxt;
   logic [31:0]     redir_tgt, tgt_nxt;
   ctl_t            ctl;

   logic dmem_wait, div_busy, load_use;

   assign dmem_wait = m_mem_req & ~dmem_ready;
   assign div_busy  = (state == IDLE && e_div) || (state == BUSY);
   assign load_use  = e_mem_read && (e_rd != 5'd0) &&
                      ((d_use_rs1 && d_rs1 == e_rd) || (d_use_rs2 && d_rs2 == e_rd));

   // Divide latency FSM; a dmem wait freezes it wherever it stands.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no latch is inferred.
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: if (e_div && !dmem_wait) begin
            state_nxt = BUSY;
            cnt_nxt   = CW'(DIV_LAT - 1);
         end
         BUSY: if (!dmem_wait) begin
            if (cnt == CW'(1)) begin
               state_nxt = DONE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         DONE: if (!dmem_wait) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      ctl      = '0;
      pend_nxt = redir_pend;
      tgt_nxt  = redir_tgt;
      if (dmem_wait) begin
         ctl.pc_stall   = 1'b1;
         ctl.f1f2_stall = 1'b1;
         ctl.f2d_stall  = 1'b1;
         ctl.de_stall   = 1'b1;
         ctl.em_stall   = 1'b1;
         ctl.mw_flush   = 1'b1;
      end else if (div_busy) begin
         ctl.pc_stall   = 1'b1;
         ctl.f1f2_stall = 1'b1;
         ctl.f2d_stall  = 1'b1;
         ctl.de_stall   = 1'b1;
         ctl.em_flush   = 1'b1;
      end else if (e_redirect) begin
         ctl.f2d_flush = 1'b1;
         ctl.de_flush  = 1'b1;
         if (imem_ready) begin
            // Taken directly, so any older pending target is stale.
            ctl.pc_redirect = 1'b1;
            ctl.pc_target   = e_target;
            ctl.f1f2_flush  = 1'b1;
            pend_nxt        = 1'b0;
         end else begin
            ctl.pc_stall   = 1'b1;
            ctl.f1f2_stall = 1'b1;
            pend_nxt       = 1'b1;
            tgt_nxt        = e_target;
         end
      end else if (redir_pend) begin
         if (imem_ready) begin
            ctl.pc_redirect = 1'b1;
            ctl.pc_target   = redir_tgt;
            ctl.f1f2_flush  = 1'b1;
            pend_nxt        = 1'b0;
         end else begin
            ctl.pc_stall   = 1'b1;
            ctl.f1f2_stall = 1'b1;
            ctl.f2d_flush  = 1'b1;
         end
      end else if (load_use) begin
         ctl.pc_stall   = 1'b1;
         ctl.f1f2_stall = 1'b1;
         ctl.f2d_stall  = 1'b1;
         ctl.de_flush   = 1'b1;
      end else if (!imem_ready) begin
         ctl.pc_stall   = 1'b1;
         ctl.f1f2_stall = 1'b1;
         ctl.f2d_flush  = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!nrst) begin
         state      <= IDLE;
         cnt        <= '0;
         redir_pend <= 1'b0;
         redir_tgt  <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         redir_pend <= pend_nxt;
         redir_tgt  <= tgt_nxt;
      end
   end

   // All outputs are forced low while reset is held.
   assign pc_stall    = nrst & ctl.pc_stall;
   assign pc_redirect = nrst & ctl.pc_redirect;
   assign pc_target   = nrst ? ctl.pc_target : 32'd0;
   assign f1f2_stall  = nrst & ctl.f1f2_stall;
   assign f1f2_flush  = nrst & ctl.f1f2_flush;
   assign f2d_stall   = nrst & ctl.f2d_stall;
   assign f2d_flush   = nrst & ctl.f2d_flush;
   assign de_stall    = nrst & ctl.de_stall;
   assign de_flush    = nrst & ctl.de_flush;
   assign em_stall    = nrst & ctl.em_stall;
   assign em_flush    = nrst & ctl.em_flush;
   assign mw_flush    = nrst & ctl.mw_flush;
   assign div_done    = nrst & (state == DONE);

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central stall/flush controller for the six-stage integer pipeline (F1, F2, D, E, M, W). It resolves five hazard sources: data-memory wait, multi-cycle divide, E-stage branch redirect, load-use, and instruction-memory wait. From these it drives the stall/flush pair of every pipeline register plus PC control. It owns the divide-latency FSM and a pending-redirect register that holds a redirect target across an instruction-memory wait.

## Interface
- DIV_LAT, 8, divide stall cycles, ≥2
- clk  in  1  clock
- nrst  in  1  synchronous active-low reset
- imem_ready  in  1  fetch word available this cycle
- dmem_ready  in  1  M-stage access complete; ignored unless m_mem_req
- m_mem_req  in  1  M-stage holds a load/store
- e_redirect  in  1  E-stage branch/jump mispredict
- e_target  in  32  redirect target
- e_div  in  1  E-stage holds div/rem
- e_mem_read  in  1  E-stage holds a load
- e_rd  in  5  E-stage destination
- d_rs1, d_rs2  in  5  D-stage sources
- d_use_rs1, d_use_rs2  in  1  source actually read
- pc_stall, pc_redirect  out  1
- pc_target  out  32
- f1f2_stall, f1f2_flush, f2d_stall, f2d_flush, de_stall, de_flush, em_stall, em_flush, mw_flush  out  1
- div_done  out  1  divide result valid in E this cycle

## Operation
- Outputs are combinational from inputs and state. While nrst=0, all outputs are 0. On reset, state → IDLE, cnt=0, redir_pend=0, redir_tgt=0.
- A register's stall and flush are never both 1. Pipeline registers give stall priority.
- Conditions are evaluated in priority order; the first match applies:
  1. dmem_wait = m_mem_req & ~dmem_ready. Stall pc, f1f2, f2d, de, em. Flush mw.
  2. div_busy = (state==IDLE & e_div) | state==BUSY. Stall pc, f1f2, f2d, de. Flush em.
  3. Redirect (e_redirect, not suppressed by 1 or 2):
     - Flush f2d and de.
     - If imem_ready=1: pc_redirect=1, pc_target=e_target, flush f1f2.
     - If imem_ready=0: latch redir_tgt=e_target, set redir_pend. Stall pc and f1f2 this cycle.
  4. redir_pend:
     - If imem_ready=0: stall pc and f1f2, flush f2d.
     - If imem_ready=1: pc_redirect=1, pc_target=redir_tgt, flush f1f2 (discards wrong-path word), clear redir_pend.
  5. Load-use: e_mem_read & e_rd≠0 & ((d_use_rs1 & d_rs1==e_rd) | (d_use_rs2 & d_rs2==e_rd)). Stall pc, f1f2, f2d. Flush de.
  6. imem_wait (imem_ready=0). Stall pc and f1f2. Flush f2d.
  7. Otherwise all outputs are 0.
- Redirect and load-use on the same cycle: the redirect wins, because the D instruction is wrong-path.
- Redirect suppressed by 1 or 2: E is held, so e_redirect re-presents and is accepted on the first unsuppressed cycle. A second redirect while redir_pend=1 overwrites redir_tgt.
- Divide FSM (IDLE, BUSY, DONE):
  - IDLE & e_div & ~dmem_wait → BUSY, with cnt=DIV_LAT-1.
  - BUSY: cnt decrements each cycle. When cnt==1 → DONE.
  - DONE: div_done=1, no divide stall, e_div ignored. If dmem_wait, remain in DONE (em stalled, result held). Else → IDLE.
  - dmem_wait also freezes cnt and state in BUSY.
- e_div and e_redirect are mutually exclusive by decode. If both are 1, the divide wins.

## Timing
- Divide accepted at cycle T (no dmem_wait):
  - Stalls are asserted T through T+DIV_LAT-1, i.e. DIV_LAT cycles.
  - div_done is high at T+DIV_LAT.
  - em captures the result at the T+DIV_LAT edge.
- Redirect with imem_ready=1: zero added latency. The target is fetched in the next cycle. Penalty is 3 bubbles (f1f2, f2d, de).
- Redirect with imem_ready=0 for N cycles: pc_redirect fires on the first imem_ready=1 cycle.
- Load-use: exactly 1 bubble. The next cycle, E holds a bubble, so the condition clears.
- Reset mid-BUSY or mid-pending: state clears on the edge and no div_done is produced.

## Test plan
- Load-use: e_mem_read=1, e_rd=5, d_rs1=5, d_use_rs1=1 → for 1 cycle: pc_stall=f1f2_stall=f2d_stall=1, de_flush=1. With e_rd=0 → no stall.
- Divide, DIV_LAT=8, e_div at T → stalls and em_flush over T..T+7, div_done=1 only at T+8, state IDLE at T+9.
- Divide with dmem_wait held for 3 cycles entering at T+8 → DONE persists, with div_done=1 and em_stall=1 for those 3 cycles.
- Redirect to 0x0000_0100 with imem_ready=0 for 2 cycles → pc_stall=1 and f2d_flush=1 during the wait. The 3rd cycle gives pc_redirect=1, pc_target=0x100, f1f2_flush=1.
- Redirect and load-use on the same cycle → de_flush=1 and f2d_flush=1, pc_redirect=1, no stalls.
- nrst=0 asserted at BUSY cnt=3 → all outputs 0 during reset. After release, e_div=0 gives no stalls and div_done is never asserted.
